data_mem_master: RTL and testbench

//  Initiator side of the byte-addressed data memory port. Accepts one 32-bit

---
 rtl/mem_pkg.sv | 14 +
 rtl/data_mem_master.sv | 114 +++++++++++
 tb/tb_data_mem_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the data memory master.
// State encodings and byte-lane geometry.
package mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t XFER = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/data_mem_master.sv
// Data memory initiator: serialises one 32-bit load/store
// into four little-endian byte transfers on a ready port.
module data_mem_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          err_q;
  logic [1:0]    cnt_q;
  logic [WW-1:0] wait_q;
  logic [23:0]   rbuf_q;
  logic [31:0]   rdata_q;

  logic misaligned;
  logic xfer;
  logic last;

  assign misaligned = ALIGN_CHECK && (addr_i[1:0] != 2'b00);
  assign xfer       = (state_q == XFER);
  assign last       = (cnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
            wait_q  <= '0;
            err_q   <= misaligned;
            state_q <= misaligned ? DONE : XFER;
          end
        end
        XFER: begin
          if (mem_ready_i) begin
            wait_q <= '0;
            // upper byte lands straight in rdata so it only moves on success
            if (!we_q) begin
              if (last) begin
                rdata_q <= {mem_rdata_i, rbuf_q};
              end else begin
                rbuf_q[8*cnt_q +: 8] <= mem_rdata_i;
              end
            end
            if (last) begin
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end else if (wait_q == WAIT_MAX) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall_o     = (state_q == IDLE) ? req_i : xfer;
  assign done_o      = (state_q == DONE);
  assign err_o       = done_o & err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = xfer ? (addr_q + {30'd0, cnt_q}) : '0;
  assign mem_wdata_o = xfer ? wdata_q[8*cnt_q +: 8] : '0;
  assign mem_we_o    = xfer & we_q;
  assign mem_re_o    = xfer & ~we_q;

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a
// byte memory model and programmable wait states.
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ready_i;

  always #5 clk = ~clk;

  data_mem_master #(
    .TIMEOUT(16),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .stall_o(stall_o),
    .done_o(done_o),
    .err_o(err_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  logic [7:0] mem [0:255] = '{default: 8'h00};
  int ws = 0;
  bit tie_low = 1'b0;
  int pend = 0;
  logic strobe;

  assign strobe      = mem_we_o | mem_re_o;
  assign mem_ready_i = strobe && !tie_low && (pend >= ws);
  assign mem_rdata_i = mem[mem_addr_o[7:0]];

  always @(posedge clk) begin
    if (strobe && mem_ready_i) begin
      pend <= 0;
      if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end else if (strobe) begin
      pend <= pend + 1;
    end else begin
      pend <= 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int w,
                     input bit tie, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd,
                     input bit exp_strb);
    int n;
    int bi;
    bit done;
    bit seen;
    logic [31:0] wd;
    ws = w;
    tie_low = tie;
    wd = wdata;
    @(negedge clk);
    req_i = 1'b1;
    we_i = we;
    addr_i = addr;
    wdata_i = wdata;
    #1;
    chk("stall_c0", stall_o, 1);
    n = 0;
    bi = 0;
    done = 1'b0;
    seen = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (done_o) begin
        done = 1'b1;
        req_i = 1'b0;
        chk("latency", n, exp_lat);
        chk("err", err_o, exp_err);
        chk("rdata", rdata_o, exp_rd);
        chk("stall_done", stall_o, 0);
        chk("strobe_done", strobe, 0);
      end else begin
        chk("stall_busy", stall_o, 1);
        if (strobe) begin
          seen = 1'b1;
          chk("we_strobe", mem_we_o, we);
          chk("addr", mem_addr_o, addr + bi);
          if (we) chk("wdata", mem_wdata_o, wd[8*bi +: 8]);
          if (mem_ready_i) bi++;
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL no_done: got none want done_o within 40");
      req_i = 1'b0;
    end
    chk("strobe_seen", seen, exp_strb);
    tie_low = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ws;
    bit          tie;
    int          lat;
    logic        err;
    logic [31:0] rd;
    bit          strb;
  } vec_t;

  vec_t v [10];

  initial begin
    v[0] = '{1'b1, 32'h8, 32'hDEADBEEF, 0, 1'b0, 5, 1'b0, 32'h0, 1'b1};
    v[1] = '{1'b0, 32'h8, 32'h0, 0, 1'b0, 5, 1'b0, 32'hDEADBEEF, 1'b1};
    v[2] = '{1'b1, 32'h10, 32'h12345678, 1, 1'b0, 9, 1'b0,
             32'hDEADBEEF, 1'b1};
    v[3] = '{1'b0, 32'h10, 32'h0, 2, 1'b0, 13, 1'b0, 32'h12345678, 1'b1};
    v[4] = '{1'b0, 32'h6, 32'h0, 0, 1'b0, 1, 1'b1, 32'h12345678, 1'b0};
    v[5] = '{1'b1, 32'h7, 32'hFFFFFFFF, 0, 1'b0, 1, 1'b1,
             32'h12345678, 1'b0};
    v[6] = '{1'b1, 32'hFFFFFFFC, 32'hA5C30F96, 0, 1'b0, 5, 1'b0,
             32'h12345678, 1'b1};
    v[7] = '{1'b0, 32'hFFFFFFFC, 32'h0, 0, 1'b0, 5, 1'b0,
             32'hA5C30F96, 1'b1};
    v[8] = '{1'b0, 32'h8, 32'h0, 0, 1'b1, 17, 1'b1, 32'hA5C30F96, 1'b1};
    v[9] = '{1'b0, 32'h8, 32'h0, 3, 1'b0, 17, 1'b0, 32'hDEADBEEF, 1'b1};

    rst_i = 1'b1;
    req_i = 1'b0;
    we_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_strobe", strobe, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(v[i].we, v[i].addr, v[i].wdata, v[i].ws, v[i].tie,
          v[i].lat, v[i].err, v[i].rd, v[i].strb);
    end
    chk("mis_store_mem", mem[7], 8'h00);

    // reset while byte 2 of a store is on the port
    ws = 0;
    @(negedge clk);
    req_i = 1'b1;
    we_i = 1'b1;
    addr_i = 32'h20;
    wdata_i = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("pre_rst_addr", mem_addr_o, 32'h22);
    rst_i = 1'b1;
    req_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobe", strobe, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done_o, 0);
    chk("partial_b0", mem[8'h20], 8'h0D);
    chk("partial_b1", mem[8'h21], 8'hF0);
    run(1'b0, 32'h8, 32'h0, 0, 1'b0, 5, 1'b0, 32'hDEADBEEF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
